// File: rtl/bip_run_controller.sv
// UART-driven run/step sequencer for the BIP core; returns a cycle/PC/ACC frame byte-by-byte.
// Optional BIP_CTRL_TIMEOUT_EN: abort RUN at counter saturation and prefix the frame with a status byte.
module bip_run_controller #(
    parameter int AB = 11,
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          tx_done,
    input  logic [4:0]    opcode,
    input  logic [AB-1:0] pc,
    input  logic [DW-1:0] acc,
    output logic          start_bip,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    output logic          busy
);

`ifdef BIP_CTRL_TIMEOUT_EN
    localparam int NB = 1 + CW/8 + 2 + DW/8;
`else
    localparam int NB = CW/8 + 2 + DW/8;
`endif
    localparam int FW = NB * 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // IDLE wait cmd | RUN exec until HALT | STEP one instr | LOAD snapshot | SEND push byte | WAIT tx_done
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_LOAD, S_SEND, S_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [7:0]    tx_last_q, tx_last_d;
    logic [15:0]   pc16;
    logic          run_ok;
    logic          cmd_run;

`ifdef BIP_CTRL_TIMEOUT_EN
    logic tmo_q, tmo_d;
    assign run_ok = (cnt_q != CNT_MAX);
`else
    assign run_ok = 1'b1;
`endif

    assign cmd_run = (state_q == S_IDLE) && rx_done && (rx_data == 8'h52);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            tx_last_q <= '0;
`ifdef BIP_CTRL_TIMEOUT_EN
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            tx_last_q <= tx_last_d;
`ifdef BIP_CTRL_TIMEOUT_EN
            tmo_q     <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_done && rx_data == 8'h52)      state_d = S_RUN;
                else if (rx_done && rx_data == 8'h53) state_d = S_STEP;
            end
            S_RUN:  if (opcode == 5'd0 || !run_ok) state_d = S_LOAD;
            S_STEP: state_d = S_LOAD;
            S_LOAD: state_d = S_SEND;
            S_SEND: state_d = S_WAIT;
            S_WAIT: if (tx_done) state_d = (idx_q == IDX_LAST) ? S_IDLE : S_SEND;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_bip = 1'b0;
        tx_start  = 1'b0;
        tx_data   = tx_last_q;
        busy      = (state_q != S_IDLE);
        case (state_q)
            S_RUN:  start_bip = (opcode != 5'd0) && run_ok;
            S_STEP: start_bip = (opcode != 5'd0);
            S_SEND: begin
                tx_start = 1'b1;
                tx_data  = frame_q[FW-1 -: 8];
            end
            default: ;
        endcase
    end

    // Frame is held as a shift register; the outgoing byte is always the top byte.
    always_comb begin
        pc16           = '0;
        pc16[AB-1:0]   = pc;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        frame_d        = frame_q;
        tx_last_d      = tx_last_q;
`ifdef BIP_CTRL_TIMEOUT_EN
        tmo_d          = tmo_q;
        if (state_q == S_RUN)  tmo_d = (cnt_q == CNT_MAX);
        if (state_q == S_STEP) tmo_d = 1'b0;
`endif
        if (cmd_run)
            cnt_d = '0;
        else if (start_bip && cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);

        case (state_q)
            S_LOAD: begin
                idx_d = '0;
`ifdef BIP_CTRL_TIMEOUT_EN
                frame_d = {(tmo_q ? 8'hEE : 8'hA5), cnt_q, pc16, acc};
`else
                frame_d = {cnt_q, pc16, acc};
`endif
            end
            S_SEND: tx_last_d = frame_q[FW-1 -: 8];
            S_WAIT: begin
                if (tx_done && idx_q != IDX_LAST) begin
                    idx_d   = idx_q + IW'(1);
                    frame_d = frame_q << 8;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bip_run_controller.sv
// Self-checking bench: a transaction-level model tracks command acceptance, executed
// cycles and the expected reply frame; every cycle the DUT outputs are compared to it.
module tb_bip_run_controller;

`ifdef BIP_CTRL_TIMEOUT_EN
    localparam int FL  = 7;
    localparam int FL8 = 6;
`else
    localparam int FL  = 6;
    localparam int FL8 = 5;
`endif
    localparam int OFF = FL - 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done, tx_done;
    logic [4:0]  opcode;
    logic [10:0] pc_env;
    logic [15:0] acc_env;
    logic        start_bip, tx_start, busy;
    logic [7:0]  tx_data;

    logic [7:0]  rx8_data;
    logic        rx8_done, tx8_done;
    logic [4:0]  opcode8;
    logic [10:0] pc8;
    logic [15:0] acc8;
    logic        start_bip8, tx_start8, busy8;
    logic [7:0]  tx_data8;

    logic [4:0]  prog [2048];

    int n_chk = 0;
    int n_err = 0;

    // model state
    bit          m_busy, m_run, outstanding, armed, auto_tx;
    logic [15:0] mcnt;
    int          m_txn, pend, ex_cnt, ex8;
    logic [7:0]  last_tx;
    logic [7:0]  cap_q[$];
    logic [7:0]  cap8_q[$];

    always #5 clk = ~clk;

    assign opcode = prog[pc_env];

    // Behaviour of the BIP core seen by the controller: PC and ACC step on each enabled cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_env  <= '0;
            acc_env <= 16'h1000;
        end else if (start_bip) begin
            pc_env  <= pc_env + 11'd1;
            acc_env <= acc_env + 16'h0123;
        end
    end

    bip_run_controller #(.AB(11), .DW(16), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .opcode(opcode), .pc(pc_env), .acc(acc_env), .start_bip(start_bip),
        .tx_data(tx_data), .tx_start(tx_start), .busy(busy)
    );

    bip_run_controller #(.AB(11), .DW(16), .CW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx8_data), .rx_done(rx8_done), .tx_done(tx8_done),
        .opcode(opcode8), .pc(pc8), .acc(acc8), .start_bip(start_bip8),
        .tx_data(tx_data8), .tx_start(tx_start8), .busy(busy8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i);
        logic [FL*8-1:0] f;
`ifdef BIP_CTRL_TIMEOUT_EN
        f = {((m_run && mcnt == 16'hFFFF) ? 8'hEE : 8'hA5), mcnt, 5'd0, pc_env, acc_env};
`else
        f = {mcnt, 5'd0, pc_env, acc_env};
`endif
        return f[(FL-1-i)*8 +: 8];
    endfunction

    // One clock: sample after the edge, update the model, compare, then drive defaults.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_busy = 0; m_run = 0; mcnt = '0; m_txn = 0;
            outstanding = 0; armed = 0; last_tx = '0; pend = 0;
            rx_done = 0; tx_done = 0; rx8_done = 0; tx8_done = 0;
            return;
        end
        if (rx_done && !m_busy && (rx_data == 8'h52 || rx_data == 8'h53)) begin
            m_busy = 1;
            m_txn  = 0;
            m_run  = (rx_data == 8'h52);
            if (m_run) mcnt = '0;
        end
        if (tx_done && outstanding) begin
            outstanding = 0;
            m_txn++;
            if (m_txn == FL) m_busy = 0;
        end
        outstanding = outstanding | armed;
        armed = 0;
        if (start_bip) begin
            ex_cnt++;
            chk("start_bip_legal", 32'(m_busy && opcode != 5'd0), 1);
`ifdef BIP_CTRL_TIMEOUT_EN
            chk("start_bip_below_max", 32'(mcnt != 16'hFFFF), 1);
`endif
            if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        end
        if (tx_start) begin
            chk("tx_start_legal", {30'd0, m_busy, outstanding | armed}, 2);
            chk($sformatf("tx_byte%0d", m_txn), tx_data, exp_byte(m_txn));
            cap_q.push_back(tx_data);
            last_tx = tx_data;
            armed = 1;
        end else begin
            chk("tx_data_hold", tx_data, last_tx);
        end
        chk("busy", busy, m_busy);
        if (start_bip8) ex8++;
        if (tx_start8) cap8_q.push_back(tx_data8);

        rx_done = 0; rx8_done = 0; tx8_done = 0; tx_done = 0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) tx_done = 1;
        end
        if (auto_tx && tx_start) pend = 3;
    endtask

    task automatic send_cmd(input logic [7:0] b);
        rx_data = b;
        rx_done = 1;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin tick(); k++; end
        chk("wait_idle", busy, 0);
    endtask

    task automatic wait_tx_start(input int budget);
        int k = 0;
        while (!tx_start && k < budget) begin tick(); k++; end
        chk("wait_tx_start", tx_start, 1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (4) tick();
        rst_n = 1;
    endtask

    task automatic chk_frame(input string nm, input logic [15:0] c, input logic [15:0] p,
                             input logic [15:0] a);
        logic [7:0] e [6];
        e[0] = c[15:8]; e[1] = c[7:0]; e[2] = p[15:8];
        e[3] = p[7:0];  e[4] = a[15:8]; e[5] = a[7:0];
        chk({nm, "_len"}, cap_q.size(), FL);
`ifdef BIP_CTRL_TIMEOUT_EN
        chk({nm, "_status"}, cap_q[0], 8'hA5);
`endif
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_b%0d", nm, i), cap_q[OFF+i], e[i]);
    endtask

    task automatic drain8();
        for (int i = 0; i < FL8; i++) begin
            int k;
            k = 0;
            while (!tx_start8 && k < 10) begin tick(); k++; end
            tick();
            tx8_done = 1;
            tick();
        end
    endtask

    initial begin
        logic [7:0] e8 [FL8];
        int k;
        rst_n = 0; rx_data = '0; rx_done = 0; tx_done = 0;
        rx8_data = '0; rx8_done = 0; tx8_done = 0; opcode8 = 5'd1;
        pc8 = 11'h123; acc8 = 16'hBEEF; auto_tx = 1; ex_cnt = 0; ex8 = 0;
        for (int i = 0; i < 2048; i++) prog[i] = (i == 5) ? 5'd0 : 5'((i % 31) + 1);

        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_start_bip", start_bip, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy8", busy8, 0);
        rst_n = 1;

        // run to HALT at PC 5
        cap_q.delete(); ex_cnt = 0;
        send_cmd(8'h52);
        wait_idle(100);
        chk("A_exec", ex_cnt, 5);
        chk_frame("A", 16'h0005, 16'h0005, 16'h15AF);

        // three single steps from reset
        do_reset();
        for (int s = 1; s <= 3; s++) begin
            cap_q.delete();
            send_cmd(8'h53);
            wait_idle(100);
            chk_frame($sformatf("B%0d", s), 16'(s), 16'(s), 16'h1000 + 16'(s) * 16'h0123);
        end

        // 'R' during WAIT and 0x41 in IDLE are ignored
        cap_q.delete();
        send_cmd(8'h53);
        wait_tx_start(20);
        tick();
        send_cmd(8'h52);
        wait_idle(100);
        chk_frame("C4", 16'h0004, 16'h0004, 16'h148C);
        cap_q.delete();
        send_cmd(8'h41);
        repeat (20) tick();
        chk("C_no_tx", cap_q.size(), 0);
        chk("C_idle", busy, 0);
        send_cmd(8'h53);
        wait_idle(100);
        cap_q.delete(); ex_cnt = 0;
        send_cmd(8'h53);
        wait_idle(100);
        chk("C_halt_step_exec", ex_cnt, 0);
        chk_frame("C_halt", 16'h0005, 16'h0005, 16'h15AF);

        // tx_done during RUN and SEND must not advance the frame
        do_reset();
        cap_q.delete();
        send_cmd(8'h52);
        tick(); tx_done = 1;
        tick(); tx_done = 1;
        tick();
        auto_tx = 0;
        wait_tx_start(20);
        tx_done = 1;
        tick(); tick(); tick();
        chk("D_one_byte", cap_q.size(), 1);
        chk("D_waiting", busy, 1);
        tx_done = 1;
        auto_tx = 1;
        wait_idle(100);
        chk_frame("D", 16'h0005, 16'h0005, 16'h15AF);

        // 8-bit counter instance: saturation / timeout
        ex8 = 0; cap8_q.delete();
        rx8_data = 8'h52; rx8_done = 1;
        tick();
`ifdef BIP_CTRL_TIMEOUT_EN
        k = 0;
        while (!tx_start8 && k < 400) begin tick(); k++; end
        chk("T_tx_start", tx_start8, 1);
        chk("T_exec", ex8, 255);
        e8[0] = 8'hEE; e8[1] = 8'hFF; e8[2] = 8'h01; e8[3] = 8'h23; e8[4] = 8'hBE; e8[5] = 8'hEF;
`else
        repeat (299) tick();
        chk("T_still_running", start_bip8, 1);
        chk("T_exec", ex8, 300);
        opcode8 = 5'd0;
        k = 0;
        while (!tx_start8 && k < 10) begin tick(); k++; end
        chk("T_tx_start", tx_start8, 1);
        e8[0] = 8'hFF; e8[1] = 8'h01; e8[2] = 8'h23; e8[3] = 8'hBE; e8[4] = 8'hEF;
`endif
        drain8();
        chk("T_len", cap8_q.size(), FL8);
        for (int i = 0; i < FL8; i++) chk($sformatf("T_b%0d", i), cap8_q[i], e8[i]);
        chk("T_idle", busy8, 0);

        // async reset in the middle of RUN
        do_reset();
        send_cmd(8'h52);
        tick();
        chk("F_running", start_bip, 1);
        #3 rst_n = 0;
        #1;
        chk("F_async_start_bip", start_bip, 0);
        chk("F_async_busy", busy, 0);
        do_reset();
        cap_q.delete(); ex_cnt = 0;
        send_cmd(8'h52);
        wait_idle(100);
        chk("F_exec", ex_cnt, 5);
        chk_frame("F1", 16'h0005, 16'h0005, 16'h15AF);

        // async reset in the middle of WAIT
        do_reset();
        cap_q.delete();
        send_cmd(8'h53);
        k = 0;
        while (cap_q.size() < FL - 1 && k < 100) begin tick(); k++; end
        tick();
        chk("F_wait_byte", tx_data, 8'h11);
        #3 rst_n = 0;
        #1;
        chk("F_async_tx_data", tx_data, 0);
        chk("F_async_tx_start", tx_start, 0);
        chk("F_async_busy2", busy, 0);
        do_reset();
        cap_q.delete();
        send_cmd(8'h53);
        wait_idle(100);
        chk_frame("F2", 16'h0001, 16'h0001, 16'h1123);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/bip_run_controller.md
# bip_run_controller

Sequencer that owns the `start_bip` enable of the BIP control block and drives it from UART commands. It:
- runs the processor until a HALT opcode, or single-steps it;
- counts executed cycles;
- returns a fixed result frame (cycle count, PC, accumulator) byte-by-byte through the UART transmitter.

It sits between the UART rx/tx pair and the BIP core.

## Interface
- `AB`, 11, PC/address width (≤16)
- `DW`, 16, accumulator width (multiple of 8)
- `CW`, 16, cycle-counter width (multiple of 8)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rx_data`  in  8  received UART byte, valid when `rx_done`=1
- `rx_done`  in  1  one-cycle pulse, new byte received
- `tx_done`  in  1  one-cycle pulse, transmitter finished current byte
- `opcode`  in  5  opcode of instruction currently addressed by the PC
- `pc`  in  AB  current PC (`Addr` of control block)
- `acc`  in  DW  current accumulator value
- `start_bip`  out  1  PC write/execute enable to the BIP control block
- `tx_data`  out  8  byte to transmit
- `tx_start`  out  1  one-cycle pulse, load `tx_data` into transmitter
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- Commands, accepted only in IDLE:
  - 0x52 'R': clear cycle counter, go to RUN.
  - 0x53 'S': go to STEP; counter is not cleared.
  - Any other byte, and any `rx_done` outside IDLE, is ignored.
- States: IDLE, RUN, STEP, LOAD, SEND, WAIT.
- RUN:
  - `start_bip` = (`opcode` ≠ 0), combinational from state and `opcode`.
  - Counter +1 on every cycle with `start_bip`=1.
  - When `opcode` = 0 (HALT), `start_bip`=0 in that cycle and next state is LOAD.
- STEP: one cycle only, with `start_bip` = (`opcode` ≠ 0) and counter +1 if asserted, then LOAD. STEP on a HALT executes nothing and still reports.
- LOAD: snapshot frame bytes MSB-first into a byte buffer and set index = 0. Frame = counter (CW/8 bytes), `pc` zero-extended to 16 bits (2 bytes), `acc` (DW/8 bytes). Default frame length is 6.
- SEND: `tx_start`=1, `tx_data` = buffer[index], then go to WAIT.
- WAIT:
  - `tx_done` at the last index → IDLE.
  - `tx_done` otherwise → index+1, then SEND.
  - `tx_done` in any other state is ignored.
- Counter saturates at 2^CW−1; it never wraps.
- `tx_data` holds the last sent byte between SENDs.

## Timing
- Reset (async, any state): state=IDLE, counter=0, index=0, `start_bip`=0, `tx_start`=0, `tx_data`=0x00, `busy`=0.
- Reset in mid-RUN drops `start_bip` immediately, without waiting for a clock edge.
- `rx_done` ('R') at edge N → RUN from cycle N+1. `start_bip` is high in cycle N+1 if `opcode` ≠ 0.
- HALT seen in RUN cycle H → LOAD at H+1, first `tx_start` at H+2.
- Snapshot in LOAD takes values present in cycle H+1. The PC is stable because `start_bip`=0.
- Next byte's `tx_start` comes one cycle after the `tx_done` pulse. `tx_start` is never asserted twice without an intervening `tx_done`.
- `busy` falls in the cycle after the last `tx_done`. A new command is accepted from that cycle on.

## Configuration
- `BIP_CTRL_TIMEOUT_EN` defined:
  - RUN aborts when the counter reaches 2^CW−1 (`start_bip` low in that cycle, then LOAD).
  - Frame is prefixed with a status byte: 0xA5 for normal HALT or STEP, 0xEE for timeout. Default frame length is 7.
- `BIP_CTRL_TIMEOUT_EN` undefined: no status byte, and RUN continues until HALT while the counter sits saturated.

## Test plan
- Program with opcode≠0 at PC 0..4 and HALT at PC 5. Send 'R' → `start_bip` high exactly 5 cycles. Frame is 00 05 00 05 + acc hi/lo (with status byte A5 first if timeout enabled).
- After reset, send 'S' three times, each reply fully drained, with `tx_done` returned 3 cycles after each `tx_start` → counter bytes in successive frames read 00 01, 00 02, 00 03. PC advances by 1 per step.
- Send 'R' while `busy` (during WAIT), then send 0x41 in IDLE → both ignored, no state change, no `tx_start`.
- Drive `tx_done` during SEND and during RUN → ignored. Index advances only on `tx_done` in WAIT, and exactly 6 (or 7) `tx_start` pulses occur per frame.
- With CW=8, program with no HALT:
  - With timeout enabled, abort after 255 counted cycles; frame is EE FF + pc + acc.
  - Without timeout, `start_bip` stays high past 300 cycles and the counter holds at FF.
- Pull `rst_n` low mid-RUN and mid-WAIT → outputs return to reset values asynchronously. First command after release behaves as from a fresh reset.
